// File: rtl/pow_n_multi_cycle_handshake.sv
// pow_n_multi_cycle_handshake
// Iterative power unit: res = n^e mod 2^W, one WxW multiply per cycle.
// valid/ready handshake on operand and result sides; a result consumed in
// DONE lets the next operand be accepted on the same edge.
// Optional overflow detection is built when POW_N_MULTI_CYCLE_OVF_EN is defined;
// otherwise ovf is tied low and only a W-bit product is formed.
module pow_n_multi_cycle_handshake #(
  parameter int W  = 8,
  parameter int EW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          n_vld,
  output logic          n_rdy,
  input  logic [W-1:0]  n,
  input  logic [EW-1:0] e,
  output logic          res_vld,
  input  logic          res_rdy,
  output logic [W-1:0]  res,
  output logic          ovf
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  n_q;
  logic [W-1:0]  acc_q;
  logic [EW-1:0] cnt_q;
  logic [W-1:0]  prod;
  logic          accept;
  logic          last_mul;

`ifdef POW_N_MULTI_CYCLE_OVF_EN
  logic [2*W-1:0] prod_full;
  logic           ovf_q;

  assign prod_full = {{W{1'b0}}, acc_q} * {{W{1'b0}}, n_q};
  assign prod      = prod_full[W-1:0];
`else
  assign prod = acc_q * n_q;
`endif

  // Ready is combinational from res_rdy so a consumed result frees the slot at once.
  assign n_rdy    = !rst && (state_q == IDLE || (state_q == DONE && res_rdy));
  assign accept   = n_vld && n_rdy;
  assign last_mul = (cnt_q == EW'(1));

  // Result outputs are only meaningful in DONE and are forced low during reset.
  assign res_vld = !rst && (state_q == DONE);
  assign res     = res_vld ? acc_q : '0;
`ifdef POW_N_MULTI_CYCLE_OVF_EN
  assign ovf     = res_vld && ovf_q;
`else
  assign ovf     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an accepted operand with e == 0 skips CALC entirely.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (e == '0) ? DONE : CALC;
      CALC: if (last_mul) state_d = DONE;
      DONE: begin
        if (accept)       state_d = (e == '0) ? DONE : CALC;
        else if (res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on acceptance, then one multiply and count-down per CALC cycle.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are cleared on reset so an aborted job leaves
    // no stale value behind for the next one.
    if (rst) begin
      n_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
`ifdef POW_N_MULTI_CYCLE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (accept) begin
      n_q   <= n;
      cnt_q <= e;
      acc_q <= W'(1);
`ifdef POW_N_MULTI_CYCLE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (state_q == CALC) begin
      acc_q <= prod;
      cnt_q <= cnt_q - EW'(1);
`ifdef POW_N_MULTI_CYCLE_OVF_EN
      if (prod_full[2*W-1:W] != '0) ovf_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_pow_n_multi_cycle_handshake.sv
// Self-checking bench for pow_n_multi_cycle_handshake (W=8, EW=4).
// Table of directed vectors, hand-written handshake/reset sequences, and
// randomized jobs checked against an arithmetic model of n^e mod 256.
module tb_pow_n_multi_cycle_handshake;

  logic       clk = 1'b0;
  logic       rst;
  logic       n_vld;
  logic       n_rdy;
  logic [7:0] n;
  logic [3:0] e;
  logic       res_vld;
  logic       res_rdy;
  logic [7:0] res;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] n;
    logic [3:0] e;
    logic [7:0] res;
    logic       ovf_en;  // expected ovf when overflow detection is built
  } vec_t;

  vec_t vecs[8];

  pow_n_multi_cycle_handshake #(.W(8), .EW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .n_vld   (n_vld),
    .n_rdy   (n_rdy),
    .n       (n),
    .e       (e),
    .res_vld (res_vld),
    .res_rdy (res_rdy),
    .res     (res),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic ovf_en);
`ifdef POW_N_MULTI_CYCLE_OVF_EN
    return ovf_en;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: exact n^e reduced mod 256; overflow means the true power reached 256.
  task automatic model(input int nn, input int ee, output logic [7:0] r, output logic o);
    int  p;
    bit  big;
    p   = 1;
    big = 0;
    for (int i = 0; i < ee; i++) begin
      p = p * nn;
      if (p >= 256) begin
        big = 1;
        p   = p % 256;
      end
    end
    r = p[7:0];
    o = exp_ovf(big);
  endtask

  // Called just after an acceptance edge; counts cycles until res_vld (-1 on timeout).
  task automatic wait_vld(output int lat);
    bit seen;
    lat  = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_vld) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!seen) lat = -1;
  endtask

  // One complete job from IDLE, with an optional stall of the consumer.
  task automatic do_job(input logic [7:0] nn, input logic [3:0] ee, input int stall,
                        input logic [7:0] er, input logic eo, input string tag);
    int lat;
    n = nn; e = ee; n_vld = 1'b1; res_rdy = (stall == 0);
    #1;
    check({tag, " n_rdy idle"}, n_rdy, 1);
    @(posedge clk); #1;
    n_vld = 1'b0;
    n = 8'($urandom);
    e = 4'($urandom);
    wait_vld(lat);
    check({tag, " latency"}, lat, ee + 1);
    if (lat > 0) begin
      check({tag, " res"}, res, er);
      check({tag, " ovf"}, ovf, eo);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check({tag, " stall hold"}, {res_vld, n_rdy, res, ovf}, {1'b1, 1'b0, er, eo});
      end
      res_rdy = 1'b1;
      #1;
      check({tag, " n_rdy on res_rdy"}, n_rdy, 1);
      @(posedge clk); #1;
      check({tag, " consumed"}, res_vld, 0);
    end
  endtask

  initial begin
    int         lat;
    logic [7:0] mr;
    logic       mo;

    vecs[0] = '{n: 8'd3,   e: 4'd4,  res: 8'd81,  ovf_en: 1'b0};
    vecs[1] = '{n: 8'd3,   e: 4'd5,  res: 8'd243, ovf_en: 1'b0};
    vecs[2] = '{n: 8'd3,   e: 4'd6,  res: 8'd217, ovf_en: 1'b1};
    vecs[3] = '{n: 8'd0,   e: 4'd0,  res: 8'd1,   ovf_en: 1'b0};
    vecs[4] = '{n: 8'd0,   e: 4'd3,  res: 8'd0,   ovf_en: 1'b0};
    vecs[5] = '{n: 8'd255, e: 4'd15, res: 8'd255, ovf_en: 1'b1};
    vecs[6] = '{n: 8'd2,   e: 4'd8,  res: 8'd0,   ovf_en: 1'b1};
    vecs[7] = '{n: 8'd1,   e: 4'd15, res: 8'd1,   ovf_en: 1'b0};

    rst = 1'b1; n_vld = 1'b0; res_rdy = 1'b0; n = '0; e = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {res_vld, res, ovf, n_rdy}, 0);
    rst = 1'b0;

    // Directed table; first job is accepted in the first cycle with rst low.
    for (int i = 0; i < 8; i++)
      do_job(vecs[i].n, vecs[i].e, 0, vecs[i].res, exp_ovf(vecs[i].ovf_en), $sformatf("vec%0d", i));

    // Backpressure: result held for 10 cycles while the next operand waits.
    res_rdy = 1'b0; n = 8'd5; e = 4'd2; n_vld = 1'b1;
    @(posedge clk); #1;
    n = 8'd2; e = 4'd3;
    wait_vld(lat);
    check("bp latency", lat, 3);
    for (int s = 0; s < 10; s++) begin
      check("bp hold", {res_vld, n_rdy, res}, {1'b1, 1'b0, 8'd25});
      @(posedge clk); #1;
    end
    res_rdy = 1'b1;
    #1;
    check("bp n_rdy", n_rdy, 1);
    @(posedge clk); #1;
    n_vld = 1'b0;
    wait_vld(lat);
    check("bp next latency", lat, 4);
    check("bp next res", res, 8);
    @(posedge clk); #1;

    // Back-to-back: each new operand accepted on the edge that consumes the result.
    res_rdy = 1'b1; n = 8'd2; e = 4'd1; n_vld = 1'b1;
    @(posedge clk); #1;
    n = 8'd2; e = 4'd2;
    wait_vld(lat);
    check("b2b lat1", lat, 2);
    check("b2b res1", res, 2);
    check("b2b n_rdy1", n_rdy, 1);
    @(posedge clk); #1;
    n = 8'd2; e = 4'd3;
    wait_vld(lat);
    check("b2b lat2", lat, 3);
    check("b2b res2", res, 4);
    check("b2b n_rdy2", n_rdy, 1);
    @(posedge clk); #1;
    n_vld = 1'b0;
    wait_vld(lat);
    check("b2b lat3", lat, 4);
    check("b2b res3", res, 8);
    @(posedge clk); #1;
    check("b2b idle", res_vld, 0);

    // Reset in cycle 3 of a 3^7 job aborts it.
    n = 8'd3; e = 4'd7; n_vld = 1'b1;
    @(posedge clk); #1;
    n_vld = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst mid outputs", {res_vld, res, ovf, n_rdy}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst release n_rdy", n_rdy, 1);
    check("rst no result", res_vld, 0);
    n = 8'd2; e = 4'd2; n_vld = 1'b1;
    @(posedge clk); #1;
    n_vld = 1'b0;
    wait_vld(lat);
    check("rst next latency", lat, 3);
    check("rst next res", res, 4);
    @(posedge clk); #1;

    // Randomized jobs against the arithmetic model.
    for (int j = 0; j < 25; j++) begin
      int rn, re, rs;
      rn = $urandom_range(0, 255);
      re = $urandom_range(0, 15);
      rs = $urandom_range(0, 3);
      model(rn, re, mr, mo);
      do_job(8'(rn), 4'(re), rs, mr, mo, $sformatf("rnd%0d n=%0d e=%0d", j, rn, re));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
